// File: rtl/vslc_input_conditioner_if.sv
// Bus between the VSLC input pins / core and the input conditioner.
// The master is the side that drives raw pins and the scan strobe (the core
// plus pad ring). The slave is the conditioner, which returns the frozen image.
interface vslc_input_conditioner_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] raw_in;
  logic             scan_cycle_clk;
  logic [WIDTH-1:0] in_image;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             image_valid;
  logic             changed;

  modport master (
    output raw_in,
    output scan_cycle_clk,
    input  in_image,
    input  rise,
    input  fall,
    input  image_valid,
    input  changed
  );

  modport slave (
    input  raw_in,
    input  scan_cycle_clk,
    output in_image,
    output rise,
    output fall,
    output image_valid,
    output changed
  );

endinterface

// File: rtl/vslc_input_conditioner.sv
// VSLC input front end: 2-FF synchroniser, per-bit debounce filter, and a
// once-per-scan image latch with rise/fall edge flags and a change pulse.
// Every output comes straight from a flop.
module vslc_input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  vslc_input_conditioner_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 1..255");
  end

  // Debounce counter step. The counter is cleared by the caller once it has
  // reached CNT_LAST, so it stops there rather than ever wrapping.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c);
    if (c >= CNT_LAST) begin
      return CNT_LAST;
    end
    return c + CNT_W'(1);
  endfunction

  // Synchroniser and debounce state
  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Scan latch state
  logic             sc_prev_q, sc_prev_d;
  logic             latch_en;
  logic [WIDTH-1:0] in_image_q, in_image_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             image_valid_q, image_valid_d;
  logic             changed_q, changed_d;

  // Synchroniser shift and per-bit debounce: a bit is accepted only after the
  // synchronised value has disagreed with filt for DEBOUNCE_CYCLES straight cycles.
  always_comb begin
    s1_d   = bus.raw_in;
    s2_d   = s1_q;
    filt_d = filt_q;
    cnt_d  = '{default: '0};
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_step(cnt_q[i]);
        end
      end
    end
  end

  // Scan image latch: capture the registered filt on each rising edge of
  // scan_cycle_clk, so a filt update in the same cycle only shows next scan.
  always_comb begin
    sc_prev_d     = bus.scan_cycle_clk;
    latch_en      = bus.scan_cycle_clk & ~sc_prev_q;
    in_image_d    = in_image_q;
    rise_d        = rise_q;
    fall_d        = fall_q;
    image_valid_d = image_valid_q;
    changed_d     = 1'b0;
    if (latch_en) begin
      in_image_d    = filt_q;
      image_valid_d = 1'b1;
      if (image_valid_q) begin
        // Edge flags compare against the image that was current until now.
        rise_d    = filt_q & ~in_image_q;
        fall_d    = ~filt_q & in_image_q;
        changed_d = |(filt_q ^ in_image_q);
      end else begin
        // First image after reset has no predecessor, so no edges are reported.
        rise_d    = '0;
        fall_d    = '0;
        changed_d = 1'b0;
      end
    end
  end

  // State registers; reset wipes everything so no partial image survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q          <= '0;
      s2_q          <= '0;
      filt_q        <= '0;
      cnt_q         <= '{default: '0};
      sc_prev_q     <= 1'b0;
      in_image_q    <= '0;
      rise_q        <= '0;
      fall_q        <= '0;
      image_valid_q <= 1'b0;
      changed_q     <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      filt_q        <= filt_d;
      cnt_q         <= cnt_d;
      sc_prev_q     <= sc_prev_d;
      in_image_q    <= in_image_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      image_valid_q <= image_valid_d;
      changed_q     <= changed_d;
    end
  end

  assign bus.in_image    = in_image_q;
  assign bus.rise        = rise_q;
  assign bus.fall        = fall_q;
  assign bus.image_valid = image_valid_q;
  assign bus.changed     = changed_q;

endmodule

// File: tb/tb_vslc_input_conditioner.sv
// Bench for vslc_input_conditioner: directed scenarios plus a randomized run
// checked against a behavioural model of the pin-to-image behaviour.
module tb_vslc_input_conditioner;

  localparam int W = 8;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  vslc_input_conditioner_if #(.WIDTH(W)) bus ();

  vslc_input_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: the last D synchronised samples are kept in a queue;
  // a filtered bit flips when all of them disagree with it.
  logic [W-1:0] m_s1 = '0, m_s2 = '0, m_filt = '0;
  logic [W-1:0] m_img = '0, m_rise = '0, m_fall = '0;
  logic         m_valid = 1'b0, m_changed = 1'b0, m_scprev = 1'b0;
  logic [W-1:0] m_hist [$];

  task automatic model_edge();
    logic [W-1:0] nf;
    logic         all_diff;
    logic         latch;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_filt = '0; m_img = '0; m_rise = '0; m_fall = '0;
      m_valid = 1'b0; m_changed = 1'b0; m_scprev = 1'b0;
      m_hist.delete();
    end else begin
      latch = bus.scan_cycle_clk && !m_scprev;
      m_hist.push_back(m_s2);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      nf = m_filt;
      if (m_hist.size() == D) begin
        for (int i = 0; i < W; i++) begin
          all_diff = 1'b1;
          foreach (m_hist[j]) if (m_hist[j][i] == m_filt[i]) all_diff = 1'b0;
          if (all_diff) nf[i] = ~m_filt[i];
        end
      end
      m_changed = 1'b0;
      if (latch) begin
        if (m_valid) begin
          m_rise    = m_filt & ~m_img;
          m_fall    = ~m_filt & m_img;
          m_changed = (m_filt != m_img);
        end else begin
          m_rise = '0; m_fall = '0;
        end
        m_img   = m_filt;
        m_valid = 1'b1;
      end
      m_filt   = nf;
      m_s2     = m_s1;
      m_s1     = bus.raw_in;
      m_scprev = bus.scan_cycle_clk;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.raw_in = 8'hFF; bus.scan_cycle_clk = 1'b0;
    tick(); tick();
    vectors++; if (bus.in_image !== 8'h00) begin miscompares++; $display("FAIL reset_in_image got %h want 00", bus.in_image); end
    vectors++; if (bus.rise !== 8'h00) begin miscompares++; $display("FAIL reset_rise got %h want 00", bus.rise); end
    vectors++; if (bus.fall !== 8'h00) begin miscompares++; $display("FAIL reset_fall got %h want 00", bus.fall); end
    vectors++; if (bus.image_valid !== 1'b0) begin miscompares++; $display("FAIL reset_image_valid got %b want 0", bus.image_valid); end
    vectors++; if (bus.changed !== 1'b0) begin miscompares++; $display("FAIL reset_changed got %b want 0", bus.changed); end
    vectors++; if (dut.filt_q !== 8'h00) begin miscompares++; $display("FAIL reset_filt got %h want 00", dut.filt_q); end
  endtask

  task automatic test_debounce_latency();
    rst = 1'b0; bus.raw_in = 8'h00;
    repeat (12) tick();
    bus.raw_in = 8'h01;
    for (int n = 0; n <= 12; n++) begin
      tick();
      vectors++;
      if (dut.filt_q[0] !== (n >= D + 1)) begin
        miscompares++; $display("FAIL debounce_filt0 edge k+%0d got %b want %b", n, dut.filt_q[0], (n >= D + 1));
      end
      vectors++;
      if (bus.in_image !== 8'h00) begin miscompares++; $display("FAIL debounce_frozen_image got %h want 00", bus.in_image); end
    end
  endtask

  task automatic test_glitch();
    bus.raw_in = 8'h09;
    repeat (5) tick();
    bus.raw_in = 8'h01;
    for (int n = 0; n < 15; n++) begin
      tick();
      vectors++;
      if (dut.filt_q !== 8'h01) begin miscompares++; $display("FAIL glitch_filt cycle %0d got %h want 01", n, dut.filt_q); end
    end
    vectors++;
    if (dut.cnt_q[3] !== '0) begin miscompares++; $display("FAIL glitch_cnt3 got %0d want 0", dut.cnt_q[3]); end
  endtask

  task automatic test_first_latch();
    rst = 1'b1; tick();
    rst = 1'b0; bus.raw_in = 8'hA5;
    repeat (12) tick();
    vectors++; if (dut.filt_q !== 8'hA5) begin miscompares++; $display("FAIL first_filt got %h want a5", dut.filt_q); end
    bus.scan_cycle_clk = 1'b1; tick();
    vectors++; if (bus.in_image !== 8'hA5) begin miscompares++; $display("FAIL first_in_image got %h want a5", bus.in_image); end
    vectors++; if (bus.image_valid !== 1'b1) begin miscompares++; $display("FAIL first_image_valid got %b want 1", bus.image_valid); end
    vectors++; if (bus.rise !== 8'h00) begin miscompares++; $display("FAIL first_rise got %h want 00", bus.rise); end
    vectors++; if (bus.fall !== 8'h00) begin miscompares++; $display("FAIL first_fall got %h want 00", bus.fall); end
    vectors++; if (bus.changed !== 1'b0) begin miscompares++; $display("FAIL first_changed got %b want 0", bus.changed); end
    bus.scan_cycle_clk = 1'b0; tick();
  endtask

  task automatic test_change();
    bus.raw_in = 8'h3C;
    repeat (12) tick();
    bus.scan_cycle_clk = 1'b1; tick();
    vectors++; if (bus.in_image !== 8'h3C) begin miscompares++; $display("FAIL change_in_image got %h want 3c", bus.in_image); end
    vectors++; if (bus.rise !== 8'h18) begin miscompares++; $display("FAIL change_rise got %h want 18", bus.rise); end
    vectors++; if (bus.fall !== 8'h81) begin miscompares++; $display("FAIL change_fall got %h want 81", bus.fall); end
    vectors++; if (bus.changed !== 1'b1) begin miscompares++; $display("FAIL change_pulse got %b want 1", bus.changed); end
    bus.scan_cycle_clk = 1'b0; tick();
    vectors++; if (bus.changed !== 1'b0) begin miscompares++; $display("FAIL change_pulse_end got %b want 0", bus.changed); end
    vectors++; if (bus.rise !== 8'h18 || bus.fall !== 8'h81) begin
      miscompares++; $display("FAIL change_hold rise %h fall %h want 18 81", bus.rise, bus.fall);
    end
    bus.scan_cycle_clk = 1'b1; tick();
    vectors++; if (bus.rise !== 8'h00) begin miscompares++; $display("FAIL nochange_rise got %h want 00", bus.rise); end
    vectors++; if (bus.fall !== 8'h00) begin miscompares++; $display("FAIL nochange_fall got %h want 00", bus.fall); end
    vectors++; if (bus.changed !== 1'b0) begin miscompares++; $display("FAIL nochange_changed got %b want 0", bus.changed); end
    bus.scan_cycle_clk = 1'b0; tick();
  endtask

  task automatic test_scan_held();
    bus.raw_in = 8'h0F; bus.scan_cycle_clk = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      vectors++;
      if (bus.in_image !== 8'h3C) begin miscompares++; $display("FAIL held_in_image cycle %0d got %h want 3c", n, bus.in_image); end
      vectors++;
      if (bus.changed !== 1'b0) begin miscompares++; $display("FAIL held_changed cycle %0d got %b want 0", n, bus.changed); end
    end
    bus.scan_cycle_clk = 1'b0; tick();
    vectors++; if (bus.in_image !== 8'h3C) begin miscompares++; $display("FAIL held_low_image got %h want 3c", bus.in_image); end
    bus.scan_cycle_clk = 1'b1; tick();
    vectors++; if (bus.in_image !== 8'h0F) begin miscompares++; $display("FAIL relatch_image got %h want 0f", bus.in_image); end
    vectors++; if (bus.rise !== 8'h03 || bus.fall !== 8'h30) begin
      miscompares++; $display("FAIL relatch_edges rise %h fall %h want 03 30", bus.rise, bus.fall);
    end
    vectors++; if (bus.changed !== 1'b1) begin miscompares++; $display("FAIL relatch_changed got %b want 1", bus.changed); end
    bus.scan_cycle_clk = 1'b0; tick();
  endtask

  task automatic test_reset_mid();
    bus.raw_in = 8'hF0;
    repeat (4) tick();
    rst = 1'b1; tick();
    vectors++; if (bus.image_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got %b want 0", bus.image_valid); end
    vectors++; if (bus.in_image !== 8'h00) begin miscompares++; $display("FAIL midrst_image got %h want 00", bus.in_image); end
    vectors++; if (dut.cnt_q[4] !== '0) begin miscompares++; $display("FAIL midrst_cnt4 got %0d want 0", dut.cnt_q[4]); end
    vectors++; if (dut.filt_q !== 8'h00) begin miscompares++; $display("FAIL midrst_filt got %h want 00", dut.filt_q); end
    rst = 1'b0;
    repeat (12) tick();
    bus.scan_cycle_clk = 1'b1; tick();
    vectors++; if (bus.in_image !== 8'hF0) begin miscompares++; $display("FAIL midrst_latch_image got %h want f0", bus.in_image); end
    vectors++; if (bus.rise !== 8'h00 || bus.fall !== 8'h00 || bus.changed !== 1'b0) begin
      miscompares++; $display("FAIL midrst_first_latch rise %h fall %h changed %b want 00 00 0", bus.rise, bus.fall, bus.changed);
    end
    vectors++; if (bus.image_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_valid_set got %b want 1", bus.image_valid); end
    bus.scan_cycle_clk = 1'b0; tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 4) == 0) bus.raw_in = bus.raw_in ^ (8'h01 << $urandom_range(0, 7));
      bus.scan_cycle_clk = ($urandom_range(0, 3) == 0);
      tick();
      vectors++; if (bus.in_image !== m_img) begin miscompares++; $display("FAIL rand_in_image cycle %0d got %h want %h", n, bus.in_image, m_img); end
      vectors++; if (bus.rise !== m_rise) begin miscompares++; $display("FAIL rand_rise cycle %0d got %h want %h", n, bus.rise, m_rise); end
      vectors++; if (bus.fall !== m_fall) begin miscompares++; $display("FAIL rand_fall cycle %0d got %h want %h", n, bus.fall, m_fall); end
      vectors++; if (bus.image_valid !== m_valid) begin miscompares++; $display("FAIL rand_valid cycle %0d got %b want %b", n, bus.image_valid, m_valid); end
      vectors++; if (bus.changed !== m_changed) begin miscompares++; $display("FAIL rand_changed cycle %0d got %b want %b", n, bus.changed, m_changed); end
      vectors++; if (dut.filt_q !== m_filt) begin miscompares++; $display("FAIL rand_filt cycle %0d got %h want %h", n, dut.filt_q, m_filt); end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.raw_in = 8'hFF;
    bus.scan_cycle_clk = 1'b0;
    test_reset();
    test_debounce_latency();
    test_glitch();
    test_first_latch();
    test_change();
    test_scan_held();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
